scan_ramp_gen: RTL and testbench

//  Triangle sweep generator feeding the peak-shape lookup stage (fun_pico .in) of the dummy simulator.

---
 rtl/scan_ramp_gen_pkg.sv | 12 +
 rtl/scan_ramp_gen_satprotect.sv | 20 ++
 rtl/scan_ramp_gen.sv | 107 ++++++++++
 tb/tb_scan_ramp_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/scan_ramp_gen_pkg.sv
// Shared constants and state type for the triangle sweep generator.
package scan_pkg;
    localparam int DAC_MAX = 8191;
    localparam int DAC_MIN = -8192;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        HOLD = 2'd3
    } state_t;
endpackage

// File: rtl/scan_ramp_gen_satprotect.sv
// Signed clamp from an Ri-bit value to the symmetric SAT-bit range, emitted on Ro bits.
module satprotect #(
    parameter int Ri  = 16,
    parameter int Ro  = 14,
    parameter int SAT = 14
) (
    input  logic signed [Ri-1:0] din,
    output logic signed [Ro-1:0] dout
);
    localparam int HI = (2 ** (SAT - 1)) - 1;
    localparam int LO = -(2 ** (SAT - 1));

    function automatic logic signed [Ro-1:0] sat(input logic signed [Ri-1:0] x);
        if (int'(x) > HI) return Ro'(HI);
        if (int'(x) < LO) return Ro'(LO);
        return $signed(x[Ro-1:0]);
    endfunction

    assign dout = sat(din);
endmodule

// File: rtl/scan_ramp_gen.sv
// Triangle sweep about a programmable offset with prescaled tick, hold and per-period strobe.
module scan_ramp_gen
    import scan_pkg::*;
#(
    parameter int DW      = 14,
    parameter int PRESC_W = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      enable,
    input  logic                      hold,
    input  logic        [DW-1:0]      step,
    input  logic        [DW-1:0]      amp,
    input  logic signed [DW-1:0]      offset,
    input  logic        [PRESC_W-1:0] presc,
    output logic signed [DW-1:0]      out,
    output logic                      dir,
    output logic                      cycle_done
);
    // Two guard bits keep acc +/- step and acc + offset free of wrap.
    localparam int AW = DW + 2;

    state_t               state;
    logic signed [AW-1:0] acc;
    logic [PRESC_W-1:0]   cnt;
    logic signed [AW-1:0] amp_c, step_x, offs_x, sum_up, sum_dn, sat_in;
    logic signed [DW-1:0] sat_q;
    logic                 tick;

    always_comb begin
        amp_c = $signed({2'b00, amp});
        if (amp_c > AW'(DAC_MAX)) amp_c = AW'(DAC_MAX);
        step_x = $signed({2'b00, step});
        offs_x = AW'(offset);
        sum_up = acc + step_x;
        sum_dn = acc - step_x;
        // acc is (or is about to be) zero whenever the sweep is idle.
        sat_in = (!enable || state == IDLE) ? offs_x : (acc + offs_x);
    end

    // >= so a presc lowered below the running count still ticks at once.
    assign tick = (cnt >= presc);

    satprotect #(.Ri(AW), .Ro(DW), .SAT(DW)) u_sat (
        .din  (sat_in),
        .dout (sat_q)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            dir        <= 1'b1;
            out        <= '0;
            cycle_done <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            if (state != HOLD || !enable) out <= sat_q;
            if (!enable) begin
                state <= IDLE;
                acc   <= '0;
                cnt   <= '0;
                dir   <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        state <= UP;
                        acc   <= '0;
                        cnt   <= '0;
                        dir   <= 1'b1;
                    end
                    HOLD: begin
                        if (!hold) state <= dir ? UP : DOWN;
                    end
                    default: begin
                        if (hold) begin
                            state <= HOLD;
                        end else if (!tick) begin
                            cnt <= cnt + PRESC_W'(1);
                        end else begin
                            cnt <= '0;
                            if (state == UP) begin
                                if (sum_up >= amp_c) begin
                                    acc   <= amp_c;
                                    state <= DOWN;
                                    dir   <= 1'b0;
                                end else begin
                                    acc <= sum_up;
                                end
                            end else begin
                                if (sum_dn <= -amp_c) begin
                                    acc        <= -amp_c;
                                    state      <= UP;
                                    dir        <= 1'b1;
                                    cycle_done <= 1'b1;
                                end else begin
                                    acc <= sum_dn;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_scan_ramp_gen.sv
// Directed and randomized sweep stimulus checked against a cycle-level arithmetic model.
module tb_scan_ramp_gen;
    localparam int DW = 14;
    localparam int PW = 32;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 enable = 1'b0;
    logic                 hold = 1'b0;
    logic        [DW-1:0] step = '0;
    logic        [DW-1:0] amp = '0;
    logic signed [DW-1:0] offset = '0;
    logic        [PW-1:0] presc = '0;
    logic signed [DW-1:0] out;
    logic                 dir;
    logic                 cycle_done;

    int checks = 0;
    int failures = 0;
    int cd_seen = 0;

    // Model: running/frozen flags, sweep value, clocks since last tick, direction.
    bit m_run, m_frz, m_rise;
    int m_acc, m_ph, m_out, m_cd;

    always #5 clk = ~clk;

    scan_ramp_gen #(.DW(DW), .PRESC_W(PW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .hold       (hold),
        .step       (step),
        .amp        (amp),
        .offset     (offset),
        .presc      (presc),
        .out        (out),
        .dir        (dir),
        .cycle_done (cycle_done)
    );

    function automatic int clamp(int v);
        if (v > 8191) return 8191;
        if (v < -8192) return -8192;
        return v;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_frz = 0; m_rise = 1;
        m_acc = 0; m_ph = 0; m_out = 0; m_cd = 0;
    endtask

    task automatic model_step();
        int a, s, o;
        a = (int'(amp) > 8191) ? 8191 : int'(amp);
        s = int'(step);
        o = int'(offset);
        m_cd = 0;
        if (!enable) begin
            m_run = 0; m_frz = 0; m_rise = 1; m_acc = 0; m_ph = 0;
            m_out = clamp(o);
        end else if (!m_run) begin
            m_run = 1;
            m_out = clamp(o);
        end else if (m_frz) begin
            if (!hold) m_frz = 0;
        end else if (hold) begin
            m_out = clamp(m_acc + o);
            m_frz = 1;
        end else begin
            m_out = clamp(m_acc + o);
            m_ph++;
            if (m_ph > int'(presc)) begin
                m_ph = 0;
                if (m_rise) begin
                    if (m_acc + s >= a) begin m_acc = a; m_rise = 0; end
                    else m_acc = m_acc + s;
                end else begin
                    if (m_acc - s <= -a) begin m_acc = -a; m_rise = 1; m_cd = 1; end
                    else m_acc = m_acc - s;
                end
            end
        end
    endtask

    task automatic cyc(string tag);
        model_step();
        @(posedge clk);
        #1;
        if (cycle_done) cd_seen++;
        chk({tag, "_out"}, int'(out), m_out);
        chk({tag, "_dir"}, int'(dir), int'(m_rise));
        chk({tag, "_cd"}, int'(cycle_done), m_cd);
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_out", int'(out), 0);
        chk("rst_dir", int'(dir), 1);
        chk("rst_cd", int'(cycle_done), 0);
        rstn = 1'b1;

        // Basic sweep +/-1000, step 100, every clock.
        presc = 0; step = 100; amp = 1000; offset = 0; enable = 1;
        cd_seen = 0;
        repeat (90) cyc("t1");
        chk("t1_cd_count", cd_seen, 2);

        // Offset pushes the upper half into saturation.
        offset = 8000;
        repeat (80) cyc("t2");

        // Prescaled sweep with a hold window.
        enable = 0; cyc("t3_idle");
        presc = 3; offset = -200; enable = 1;
        repeat (30) cyc("t3_run");
        hold = 1;
        repeat (10) cyc("t3_hold");
        hold = 0;
        repeat (30) cyc("t3_resume");

        // Zero amplitude: turnaround every tick.
        enable = 0; cyc("t4_idle");
        presc = 0; amp = 0; step = 5; offset = 300; enable = 1;
        cd_seen = 0;
        repeat (12) cyc("t4");
        chk("t4_cd_count", cd_seen, 5);

        // Amplitude reduced below the current point while rising.
        enable = 0; cyc("t5_idle");
        amp = 1000; step = 100; offset = 0; enable = 1;
        for (int i = 0; i < 50; i++) begin
            cyc("t5_run");
            if (m_acc == 800 && m_rise) break;
        end
        amp = 500;
        cyc("t5_clamp");
        chk("t5_dir_now", int'(dir), 0);
        cyc("t5_out");
        chk("t5_out_500", int'(out), 500);
        repeat (10) cyc("t5_desc");

        // Step larger than the full swing alternates between the limits.
        amp = 50; step = 200;
        repeat (10) cyc("t7");

        // Randomized configuration segments with sporadic hold/enable drops.
        for (int seg = 0; seg < 40; seg++) begin
            step   = DW'($urandom_range(0, 3000));
            amp    = DW'($urandom_range(0, 16383));
            offset = $signed(DW'($urandom_range(0, 16383)));
            presc  = PW'($urandom_range(0, 3));
            enable = ($urandom_range(0, 9) != 0);
            for (int k = 0, n = $urandom_range(5, 40); k < n; k++) begin
                hold = ($urandom_range(0, 7) == 0);
                cyc("rnd");
            end
        end
        hold = 0;

        // Asynchronous reset between edges mid-sweep.
        enable = 0; cyc("t6_idle");
        presc = 0; step = 100; amp = 1000; offset = 0; enable = 1;
        repeat (15) cyc("t6_run");
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("t6_async_out", int'(out), 0);
        chk("t6_async_dir", int'(dir), 1);
        chk("t6_async_cd", int'(cycle_done), 0);
        model_reset();
        enable = 0; offset = 1234;
        #1 rstn = 1'b1;
        cyc("t6_idle_after");
        chk("t6_offset_out", int'(out), 1234);
        enable = 1;
        repeat (20) cyc("t6_restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
